// File: rtl/tamagotchi_stats_core.sv
// Multi-channel pet stat tracker: per-stat decay, feed buttons, NORMAL/TEST modes and
// hold-to-fire soft reset / test toggle. Optional low-level alarm under TAMA_STATS_ALARM_EN.
module tamagotchi_stats_core #(
  parameter int                   N_STATS     = 4,
  parameter int                   LVL_W       = 4,
  parameter int                   LVL_MAX     = 10,
  parameter int                   LVL_INIT    = 8,
  parameter int                   HAPPY_TH    = 5,
  parameter int                   TICK_DIV    = 50000000,
  parameter int                   HOLD_TICKS  = 5,
  parameter logic [8*N_STATS-1:0] DECAY_TICKS = {8'd50, 8'd70, 8'd100, 8'd120},
  parameter int                   ALARM_TH    = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_STATS-1:0]         btn_stat,
  input  logic                       btn_reset,
  input  logic                       btn_test,
  output logic [$clog2(N_STATS)-1:0] sel,
  output logic [LVL_W-1:0]           level_out,
  output logic [N_STATS*LVL_W-1:0]   levels_flat,
  output logic                       happy,
  output logic [6:0]                 seg,
  output logic                       test_mode,
  output logic                       alarm
);

  localparam int SEL_W  = $clog2(N_STATS);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX_V  = LVL_W'(LVL_MAX);
  localparam logic [LVL_W-1:0] LVL_INIT_V = LVL_W'(LVL_INIT);
  localparam logic             HAPPY_INIT = (LVL_INIT >= HAPPY_TH);

  typedef enum logic {MODE_NORMAL = 1'b0, MODE_TEST = 1'b1} mode_e;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'b0111111;  4'h1: seg_code = 7'b0000110;
      4'h2: seg_code = 7'b1011011;  4'h3: seg_code = 7'b1001111;
      4'h4: seg_code = 7'b1100110;  4'h5: seg_code = 7'b1101101;
      4'h6: seg_code = 7'b1111101;  4'h7: seg_code = 7'b0000111;
      4'h8: seg_code = 7'b1111111;  4'h9: seg_code = 7'b1101111;
      4'hA: seg_code = 7'b1110111;  4'hB: seg_code = 7'b1111100;
      4'hC: seg_code = 7'b0111001;  4'hD: seg_code = 7'b1011110;
      4'hE: seg_code = 7'b1111001;  default: seg_code = 7'b1110001;
    endcase
  endfunction

  localparam logic [6:0] SEG_INIT = seg_code(4'(LVL_INIT));

  logic [PRE_W-1:0]  presc_q;
  logic              tick;
  logic [1:0]        hold_btn, hold_fire;
  logic [HOLD_W-1:0] hold_q [2];
  logic              srst_fire, test_fire;
  logic [N_STATS-1:0] btn_q, edges, feed, decay_hit;
  logic              win_valid;
  logic [SEL_W-1:0]  win_idx;

  mode_e             mode_q, mode_d;
  logic [SEL_W-1:0]  sel_q, sel_d, arm_idx_q, arm_idx_d;
  logic              arm_valid_q, arm_valid_d;
  logic [LVL_W-1:0]  levels_q [N_STATS];
  logic [LVL_W-1:0]  levels_d [N_STATS];
  logic [7:0]        decay_q  [N_STATS];
  logic [7:0]        decay_d  [N_STATS];

  assign tick      = (presc_q == PRE_W'(TICK_DIV - 1));
  assign hold_btn  = {btn_test, btn_reset};
  assign srst_fire = hold_fire[0];
  assign test_fire = hold_fire[1];
  assign edges     = btn_stat & ~btn_q;

  // Prescaler, button history and hold counters track the physical inputs, so a
  // soft reset leaves them alone; a still-held reset button therefore cannot re-fire.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      btn_q   <= '0;
      for (int k = 0; k < 2; k++) hold_q[k] <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      btn_q   <= btn_stat;
      for (int k = 0; k < 2; k++) begin
        if (!hold_btn[k])                                  hold_q[k] <= '0;
        else if (tick && hold_q[k] != HOLD_W'(HOLD_TICKS)) hold_q[k] <= hold_q[k] + 1'b1;
      end
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = N_STATS - 1; i >= 0; i--) begin
      if (edges[i]) begin
        win_valid = 1'b1;
        win_idx   = SEL_W'(i);
      end
    end
    for (int k = 0; k < 2; k++)
      hold_fire[k] = hold_btn[k] && tick && (hold_q[k] == HOLD_W'(HOLD_TICKS - 1));
    for (int i = 0; i < N_STATS; i++) begin
      feed[i]      = win_valid && (win_idx == SEL_W'(i));
      decay_hit[i] = tick && (DECAY_TICKS[8*i +: 8] != 8'd0) &&
                     (decay_q[i] == DECAY_TICKS[8*i +: 8] - 8'd1);
    end
  end

  always_comb begin
    mode_d      = mode_q;
    sel_d       = sel_q;
    arm_valid_d = arm_valid_q;
    arm_idx_d   = arm_idx_q;
    levels_d    = levels_q;
    decay_d     = decay_q;
    if (srst_fire) begin
      mode_d      = MODE_NORMAL;
      sel_d       = '0;
      arm_valid_d = 1'b0;
      arm_idx_d   = '0;
      for (int i = 0; i < N_STATS; i++) begin
        levels_d[i] = LVL_INIT_V;
        decay_d[i]  = '0;
      end
    end else begin
      if (mode_q == MODE_NORMAL) begin
        if (win_valid) sel_d = win_idx;
        for (int i = 0; i < N_STATS; i++) begin
          if (tick && DECAY_TICKS[8*i +: 8] != 8'd0)
            decay_d[i] = decay_hit[i] ? 8'd0 : decay_q[i] + 8'd1;
          // A feed and a decay on the same stat cancel out.
          if (feed[i] && !decay_hit[i] && levels_q[i] < LVL_MAX_V)
            levels_d[i] = levels_q[i] + 1'b1;
          else if (decay_hit[i] && !feed[i] && levels_q[i] != '0)
            levels_d[i] = levels_q[i] - 1'b1;
        end
      end else if (win_valid) begin
        if (arm_valid_q && arm_idx_q == win_idx) begin
          levels_d[win_idx] = (levels_q[win_idx] == LVL_W'(1)) ? LVL_MAX_V : LVL_W'(1);
        end else begin
          sel_d       = win_idx;
          arm_valid_d = 1'b1;
          arm_idx_d   = win_idx;
        end
      end
      if (test_fire) begin
        arm_valid_d = 1'b0;
        arm_idx_d   = '0;
        if (mode_q == MODE_TEST) begin
          mode_d = MODE_NORMAL;
          for (int i = 0; i < N_STATS; i++) decay_d[i] = '0;
        end else begin
          mode_d = MODE_TEST;
        end
      end
    end
  end

  // NOTE: the level/decay arrays are plain flops, not RAM, so they take the async reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_NORMAL;
      sel_q       <= '0;
      arm_valid_q <= 1'b0;
      arm_idx_q   <= '0;
      for (int i = 0; i < N_STATS; i++) begin
        levels_q[i] <= LVL_INIT_V;
        decay_q[i]  <= '0;
      end
    end else begin
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      arm_valid_q <= arm_valid_d;
      arm_idx_q   <= arm_idx_d;
      levels_q    <= levels_d;
      decay_q     <= decay_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_out <= LVL_INIT_V;
      happy     <= HAPPY_INIT;
      seg       <= SEG_INIT;
    end else if (srst_fire) begin
      level_out <= LVL_INIT_V;
      happy     <= HAPPY_INIT;
      seg       <= SEG_INIT;
    end else begin
      level_out <= levels_q[sel_q];
      happy     <= int'(levels_q[sel_q]) >= HAPPY_TH;
      seg       <= seg_code(4'(levels_q[sel_q]));
    end
  end

  for (genvar g = 0; g < N_STATS; g++) begin : g_flat
    assign levels_flat[g*LVL_W +: LVL_W] = levels_q[g];
  end

  assign sel       = sel_q;
  assign test_mode = (mode_q == MODE_TEST);

`ifdef TAMA_STATS_ALARM_EN
  logic any_low, any_zero, alarm_q;

  always_comb begin
    any_low  = 1'b0;
    any_zero = 1'b0;
    for (int i = 0; i < N_STATS; i++) begin
      if (int'(levels_q[i]) <= ALARM_TH) any_low  = 1'b1;
      if (levels_q[i] == '0)             any_zero = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             alarm_q <= 1'b0;
    else if (srst_fire || mode_q == MODE_TEST) alarm_q <= 1'b0;
    else if (any_zero)                      alarm_q <= tick ? ~alarm_q : alarm_q;
    else                                    alarm_q <= any_low;
  end

  assign alarm = alarm_q;
`else
  // Threshold only matters when the alarm is built.
  logic unused_alarm_th;
  assign unused_alarm_th = (ALARM_TH != 0);
  assign alarm           = 1'b0;
`endif

endmodule

// File: doc/tamagotchi_stats_core.md
Name: tamagotchi_stats_core

Overview:
Parametrised successor of the pet-state FSM. It tracks N_STATS independent pet levels, for example health, energy, hunger and fun. Each level decays on its own tick period, rises on a feed button press, and is held by a NORMAL/TEST mode machine. Soft-reset and test entry/exit both use timed button holds. It sits between the debounced button block and the display/face driver, and outputs the selected stat, its level, 7-seg code, happy flag and alarm.

Parameters:
N_STATS, 4, number of stat channels (2..8)
LVL_W, 4, level width in bits
LVL_MAX, 10, saturation ceiling (<= 2^LVL_W-1)
LVL_INIT, 8, level after reset
HAPPY_TH, 5, happy when selected level >= HAPPY_TH
TICK_DIV, 50000000, clk cycles per internal tick (1 s at 50 MHz)
HOLD_TICKS, 5, ticks a button must be held for soft-reset/test toggle
DECAY_TICKS, {8'd50,8'd70,8'd100,8'd120}, packed 8 bits per stat, stat0 in LSBs; 0 disables decay for that stat
ALARM_TH, 2, alarm threshold (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_stat  in  N_STATS  debounced level-high feed/select buttons, bit i = stat i
btn_reset  in  1  debounced soft-reset button
btn_test  in  1  debounced test-mode button
sel  out  clog2(N_STATS)  currently displayed stat
level_out  out  LVL_W  level of sel
levels_flat  out  N_STATS*LVL_W  all levels, stat0 in LSBs
happy  out  1  face: 1 happy, 0 sad
seg  out  7  gfedcba active-high digit of level_out
test_mode  out  1  1 while in TEST
alarm  out  1  low-level alarm (optional feature)

Behaviour:
- Async reset (rst_n=0): all levels=LVL_INIT, all decay/hold/prescaler counters=0, mode NORMAL, sel=0, test arm cleared, happy=(LVL_INIT>=HAPPY_TH), seg=code(LVL_INIT), alarm=0, test_mode=0. Outputs take these values immediately, not on the next clk edge.
- Prescaler: counts 0..TICK_DIV-1. The tick strobe is 1 for one cycle when the count wraps.
- Button presses are detected by rising edge against a registered copy. A button held for multiple cycles counts once.
- Simultaneous stat edges: the lowest index wins; the others are ignored that cycle.
- NORMAL mode:
  - A stat edge on i sets sel=i and level[i]=min(level[i]+1, LVL_MAX).
  - Decay counter i increments on tick. When it reaches DECAY_TICKS[i]-1 it clears to 0 and level[i]=max(level[i]-1, 0).
  - Feed and decay on the same stat in the same cycle: the level is unchanged.
- TEST mode:
  - Decay counters are frozen and keep their values.
  - A stat edge on i with the arm clear, or armed to a different stat j≠i: sel=i, arm=i, level unchanged.
  - A second edge on the same armed stat i: level[i]=(level[i]==1)?LVL_MAX:1, and arm stays set.
- Hold counters (btn_reset, btn_test):
  - Each counter increments per tick while its button is high and clears when the button is released.
  - When it reaches HOLD_TICKS it fires a one-cycle event and saturates. There is no re-fire until the button is released.
- Soft-reset event: everything returns to the rst_n values, except the prescaler, which keeps running. It takes priority over every other event in that cycle.
- Test event: toggles NORMAL<->TEST, clears the arm, and zeroes the decay counters on entry to NORMAL.
- Both hold events in the same cycle: soft-reset wins and the mode goes to NORMAL.
- Outputs are registered with 1-cycle latency from the level/sel update:
  - level_out = level[sel]
  - happy = level[sel] >= HAPPY_TH
  - seg = hex code of level_out[3:0] (0-9, A, b, C, d, E, F)
- Levels never wrap in either direction.

Optional Feature:
Macro TAMA_STATS_ALARM_EN.
- Defined: alarm=1 while any level <= ALARM_TH. In NORMAL mode, alarm blinks at half the tick rate (toggles each tick) when any level == 0. alarm is registered and forced to 0 in TEST.
- Undefined: alarm is tied to 0 and no alarm logic is built.

Test Plan:
Bench parameters: TICK_DIV=4, HOLD_TICKS=5, DECAY_TICKS={3,4,5,6}.
- Reset: rst_n low mid-run -> levels_flat=0x8888, sel=0, happy=1, seg=7'b1111111, test_mode=0, asynchronously.
- Feed saturation: 3 edges on btn_stat[2] with no ticks -> level2 goes 8,9,10,10, sel=2, seg=7'b1110111.
- Decay: 48 ticks with no buttons -> stat0 loses 8 (period 6) and reaches 0, then stays at 0. Stat3 (period 3) reaches 0 after 24 ticks. happy follows sel=0 and drops when level0 reaches 4.
- Simultaneous events:
  - btn_stat=4'b0110 edge -> only stat1 increments.
  - A feed coinciding with a stat0 decay tick -> level0 is unchanged.
- Test mode: btn_test held for 5 ticks -> test_mode=1.
  - btn_stat[1] edge -> sel=1, level unchanged.
  - Second btn_stat[1] edge -> level1=1; third edge -> 10.
  - 30 ticks pass -> no decay.
  - Hold btn_test for 5 ticks again -> test_mode=0.
- Soft reset: btn_reset held 4 ticks then released -> no effect. Held 5 ticks -> levels_flat=0x8888 and mode NORMAL. Still held afterwards -> no second event.
